// File: rtl/alu_op_sequencer.sv
// Issue-side sequencer for an external 8-bit combinational ALU: accepts instructions, drives operands, writes the register file, returns results.
// Optional build macro ALU_SEQ_ZERO_FLAG_EN adds the res_zero response output.
module alu_op_sequencer #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [19:0]           instr,
    output logic [DATA_W-1:0]     A,
    output logic [DATA_W-1:0]     B,
    output logic [2:0]            ALU_Sel,
    input  logic [DATA_W-1:0]     Out,
    input  logic                  Cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_W-1:0]     res_data,
    output logic [REG_ADDR_W-1:0] res_rd,
    output logic                  res_carry
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    output logic                  res_zero
`endif
);

    localparam int NREG = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0]     rf [NREG];
    logic                  carry;
    logic [2:0]            op_p0;
    logic [REG_ADDR_W-1:0] rd_p0;
    logic                  carry_p1;

    logic                  ldi_f;
    logic [2:0]            op_f;
    logic [REG_ADDR_W-1:0] rd_f;
    logic [REG_ADDR_W-1:0] rs1_f;
    logic [REG_ADDR_W-1:0] rs2_f;
    logic [DATA_W-1:0]     imm_f;
    logic                  accept;
    logic                  unused_reserved;

    // Only add (000) and subtract (001) produce a meaningful carry/borrow.
    function automatic logic carry_update(input logic [2:0] op, input logic cin, input logic cur);
        return (op == 3'b000 || op == 3'b001) ? cin : cur;
    endfunction

    function automatic logic is_zero(input logic [DATA_W-1:0] value);
        return (value == '0);
    endfunction

    assign ldi_f           = instr[19];
    assign op_f            = instr[18:16];
    assign rd_f            = REG_ADDR_W'(instr[15:14]);
    assign rs1_f           = REG_ADDR_W'(instr[13:12]);
    assign rs2_f           = REG_ADDR_W'(instr[11:10]);
    assign imm_f           = DATA_W'(instr[7:0]);
    assign unused_reserved = ^instr[9:8];

    assign instr_ready = (state == IDLE);
    assign accept      = instr_valid && instr_ready;
    assign carry_p1    = carry_update(op_p0, Cout, carry);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ldi_f ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = RESP;
            RESP: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
            carry     <= 1'b0;
            A         <= '0;
            B         <= '0;
            ALU_Sel   <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
            res_carry <= 1'b0;
        end else begin
            case (state)
                // p0: accept; ALU ops latch operands, LDI completes immediately
                IDLE: begin
                    if (accept) begin
                        if (ldi_f) begin
                            rf[rd_f]  <= imm_f;
                            res_data  <= imm_f;
                            res_rd    <= rd_f;
                            res_carry <= carry;
                            res_valid <= 1'b1;
                        end else begin
                            A       <= rf[rs1_f];
                            B       <= rf[rs2_f];
                            ALU_Sel <= op_f;
                            op_p0   <= op_f;
                            rd_p0   <= rd_f;
                        end
                    end
                end
                // p1: ALU result captured at the end of ISSUE
                ISSUE: begin
                    rf[rd_p0] <= Out;
                    res_data  <= Out;
                    res_rd    <= rd_p0;
                    carry     <= carry_p1;
                    res_carry <= carry_p1;
                    res_valid <= 1'b1;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: res_valid <= 1'b0;
            endcase
        end
    end

`ifdef ALU_SEQ_ZERO_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            res_zero <= 1'b0;
        end else if (accept && ldi_f) begin
            res_zero <= is_zero(imm_f);
        end else if (state == ISSUE) begin
            res_zero <= is_zero(Out);
        end
    end
`else
    logic unused_zero_fn;
    assign unused_zero_fn = is_zero(Out);
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the external ALU.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [19:0] instr;
    logic [7:0]  A, B, Out;
    logic [2:0]  ALU_Sel;
    logic        Cout;
    logic        res_valid, res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_rd;
    logic        res_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic        res_zero;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.DATA_W(8), .REG_ADDR_W(2)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .A(A), .B(B), .ALU_Sel(ALU_Sel), .Out(Out), .Cout(Cout),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_rd(res_rd), .res_carry(res_carry)
`ifdef ALU_SEQ_ZERO_FLAG_EN
        , .res_zero(res_zero)
`endif
    );

    // External ALU: add, sub(borrow), and, or, xor, mul, shr, shl
    logic [8:0]  sum9;
    logic [15:0] prod;
    always_comb begin
        sum9 = {1'b0, A} + {1'b0, B};
        prod = A * B;
        Out  = 8'h00;
        Cout = 1'b0;
        case (ALU_Sel)
            3'b000: begin Out = sum9[7:0]; Cout = sum9[8]; end
            3'b001: begin Out = A - B;     Cout = (A < B); end
            3'b010: Out = A & B;
            3'b011: Out = A | B;
            3'b100: Out = A ^ B;
            3'b101: begin Out = prod[7:0]; Cout = |prod[15:8]; end
            3'b110: begin Out = A >> 1;    Cout = A[0]; end
            default: begin Out = A << 1;   Cout = A[7]; end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic ldi, input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
        return {ldi, op, rd, rs1, rs2, 2'b11, imm};
    endfunction

    task automatic send(input logic [19:0] w);
        instr_valid = 1'b1;
        instr       = w;
        check("instr_ready_before_accept", instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr       = 20'h00000;
    endtask

    task automatic check_resp(input string tag, input logic [7:0] d, input logic [1:0] rd, input logic c);
        check({tag, "_valid"}, res_valid, 1);
        check({tag, "_data"},  res_data,  d);
        check({tag, "_rd"},    res_rd,    rd);
        check({tag, "_carry"}, res_carry, c);
`ifdef ALU_SEQ_ZERO_FLAG_EN
        check({tag, "_zero"},  res_zero,  (d == 8'h00));
`endif
    endtask

    task automatic do_ldi(input string tag, input logic [1:0] rd, input logic [7:0] imm, input logic c);
        send(mk(1'b1, 3'b101, rd, 2'd3, 2'd2, imm));
        check_resp(tag, imm, rd, c);
        @(posedge clk); #1;
        check({tag, "_done_valid"}, res_valid, 0);
        check({tag, "_done_ready"}, instr_ready, 1);
    endtask

    task automatic do_alu(input string tag, input logic [2:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] d, input logic c);
        send(mk(1'b0, op, rd, rs1, rs2, 8'hA5));
        check({tag, "_issue_valid"}, res_valid, 0);
        check({tag, "_A"}, A, ea);
        check({tag, "_B"}, B, eb);
        check({tag, "_sel"}, ALU_Sel, op);
        @(posedge clk); #1;
        check_resp(tag, d, rd, c);
        @(posedge clk); #1;
        check({tag, "_done_valid"}, res_valid, 0);
        check({tag, "_done_ready"}, instr_ready, 1);
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 20'h00000;
        res_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_instr_ready", instr_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_sel", ALU_Sel, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_rd", res_rd, 0);
        check("rst_res_carry", res_carry, 0);

        do_ldi("ldi_r0_3c", 2'd0, 8'h3C, 1'b0);
        do_ldi("ldi_r1_0f", 2'd1, 8'h0F, 1'b0);
        do_alu("add_r2", 3'b000, 2'd2, 2'd0, 2'd1, 8'h3C, 8'h0F, 8'h4B, 1'b0);

        do_ldi("ldi_r0_ff", 2'd0, 8'hFF, 1'b0);
        do_ldi("ldi_r1_01", 2'd1, 8'h01, 1'b0);
        do_alu("add_carry", 3'b000, 2'd3, 2'd0, 2'd1, 8'hFF, 8'h01, 8'h00, 1'b1);
        do_alu("and_hold", 3'b010, 2'd2, 2'd0, 2'd1, 8'hFF, 8'h01, 8'h01, 1'b1);

        do_ldi("ldi_carry_keep", 2'd0, 8'h81, 1'b1);
        do_alu("shl_inplace", 3'b111, 2'd0, 2'd0, 2'd0, 8'h81, 8'h81, 8'h02, 1'b1);
        do_alu("shr_r1", 3'b110, 2'd1, 2'd0, 2'd0, 8'h02, 8'h02, 8'h01, 1'b1);
        do_alu("sub_clear", 3'b001, 2'd2, 2'd0, 2'd1, 8'h02, 8'h01, 8'h01, 1'b0);
        do_ldi("ldi_r3_20", 2'd3, 8'h20, 1'b0);
        do_alu("mul_trunc", 3'b101, 2'd3, 2'd3, 2'd3, 8'h20, 8'h20, 8'h00, 1'b0);

        // Backpressure with a pending instruction that changes while stalled
        res_ready = 1'b0;
        send(mk(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h55));
        check_resp("bp_first", 8'h55, 2'd2, 1'b0);
        instr_valid = 1'b1;
        instr       = mk(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h11);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 2) instr = mk(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'hAA);
            check_resp("bp_hold", 8'h55, 2'd2, 1'b0);
            check("bp_instr_ready", instr_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_hs_valid", res_valid, 0);
        check("bp_hs_ready", instr_ready, 1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check_resp("bp_second", 8'hAA, 2'd1, 1'b0);
        @(posedge clk); #1;
        check("bp_second_done", res_valid, 0);

        // Reset during ISSUE of ADD r2 = r0 + r1 (r0=02, r1=AA)
        send(mk(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00));
        check("rstmid_A", A, 8'h02);
        check("rstmid_B", B, 8'hAA);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstmid_valid", res_valid, 0);
        check("rstmid_ready", instr_ready, 1);
        check("rstmid_A0", A, 0);
        check("rstmid_B0", B, 0);
        check("rstmid_sel0", ALU_Sel, 0);
        check("rstmid_carry0", res_carry, 0);
        do_alu("or_r2_cleared", 3'b011, 2'd3, 2'd2, 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
